// File: rtl/servo_pwm_decoder_pkg.sv
// Shared constants, decoder state type and angle clamp for the servo PWM generator/decoder pair.
package servo_pwm_decoder_pkg;

    localparam int SERVO_MIN_HIGH    = 25_000;
    localparam int SERVO_MAX_HIGH    = 125_000;
    localparam int SERVO_CYC_PER_DEG = 555;
    localparam int SERVO_ANGLE_MAX   = 180;
    localparam int SERVO_PERIOD_CYC  = 1_000_000;
    localparam int SERVO_TIMEOUT_CYC = 2_000_000;
    localparam int SERVO_FILT_LEN    = 16;

    localparam int DVD_W = 17;
    localparam int QUO_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_CONV,
        ST_LOW
    } dec_state_e;

    function automatic logic [QUO_W-1:0] clamp_angle(input logic [QUO_W-1:0] q);
        return (q > QUO_W'(SERVO_ANGLE_MAX)) ? QUO_W'(SERVO_ANGLE_MAX) : q;
    endfunction

endpackage

// File: rtl/pwm_angle_div.sv
// Restoring divider by a constant: 17-bit dividend, 8-bit quotient, one bit per cycle MSB first.
module pwm_angle_div
    import servo_pwm_decoder_pkg::*;
#(
    parameter int DIVISOR = SERVO_CYC_PER_DEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [QUO_W-1:0] quotient_o
);

    localparam int SW = DVD_W + QUO_W;
    localparam int CW = $clog2(QUO_W);
    localparam logic [SW-1:0] DSH_INIT = SW'(DIVISOR) << (QUO_W - 1);

    logic [SW-1:0]    rem_q, rem_d, dsh_q, dsh_d;
    logic [QUO_W-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    // The shifted divisor walks down one position per cycle, so quotient bit i
    // is decided by comparing the remainder against DIVISOR << i.
    always_comb begin
        rem_d  = rem_q;
        dsh_d  = dsh_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            if (rem_q >= dsh_q) begin
                rem_d = rem_q - dsh_q;
                quo_d = {quo_q[QUO_W-2:0], 1'b1};
            end else begin
                quo_d = {quo_q[QUO_W-2:0], 1'b0};
            end
            dsh_d = dsh_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(QUO_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            rem_d  = SW'(dividend_i);
            dsh_d  = DSH_INIT;
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsh_q  <= dsh_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures incoming high time and converts it to an angle 0..180.
// Define PWM_GLITCH_FILTER_EN to add a FILT_LEN-sample glitch filter on the synchronised input.
module servo_pwm_decoder
    import servo_pwm_decoder_pkg::*;
#(
    parameter int MIN_HIGH    = SERVO_MIN_HIGH,
    parameter int MAX_HIGH    = SERVO_MAX_HIGH,
    parameter int CYC_PER_DEG = SERVO_CYC_PER_DEG,
    parameter int TIMEOUT_CYC = SERVO_TIMEOUT_CYC,
`ifdef PWM_GLITCH_FILTER_EN
    parameter int FILT_LEN    = SERVO_FILT_LEN,
`endif
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [7:0]       angle_out,
    output logic             angle_valid,
    output logic [CNT_W-1:0] width_out,
    output logic             range_err,
    output logic             signal_lost
);

    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] MAXP1_W = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0] TO_W    = CNT_W'(TIMEOUT_CYC);

    logic [1:0] sync_q;
    logic       lvl, prev_q, rise_q, fall_q;

    // Input registers reset high: a level already high at reset exit makes no
    // rise, and the fall it eventually produces is ignored in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic          filt_q;
    logic [FW-1:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (sync_q[1] == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
            filt_q <= sync_q[1];
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, since_q, since_d, width_q, width_d, hi_inc;
    logic [7:0]       angle_q, angle_d;
    logic             pend_q, pend_d, valid_q, valid_d, rerr_q, rerr_d, lost_q, lost_d;
    logic             timeout_hit, div_start, div_busy, div_done;
    logic [DVD_W-1:0] div_dividend;
    logic [QUO_W-1:0] div_quo;

    assign timeout_hit  = !rise_q && (since_q == TO_W - 1'b1);
    assign hi_inc       = (hi_cnt_q == MAXP1_W) ? hi_cnt_q : hi_cnt_q + 1'b1;
    assign div_dividend = (state_q == ST_CONV) ? DVD_W'(width_q - MIN_W) : DVD_W'(hi_cnt_q - MIN_W);

    // A rise during CONV restarts hi_cnt immediately so the next pulse keeps its exact width.
    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        pend_d    = pend_q;
        width_d   = width_q;
        angle_d   = angle_q;
        valid_d   = 1'b0;
        rerr_d    = 1'b0;
        lost_d    = lost_q;
        div_start = 1'b0;
        since_d   = rise_q ? '0 : ((since_q == TO_W) ? since_q : since_q + 1'b1);
        if (timeout_hit) begin
            state_d = ST_IDLE;
            lost_d  = 1'b1;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOW: begin
                    if (rise_q) begin
                        state_d  = ST_HIGH;
                        hi_cnt_d = CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall_q) begin
                        width_d = hi_cnt_q;
                        if (hi_cnt_q >= MIN_W && hi_cnt_q <= MAX_W) begin
                            div_start = 1'b1;
                            pend_d    = 1'b0;
                            state_d   = ST_CONV;
                        end else begin
                            rerr_d  = 1'b1;
                            state_d = ST_LOW;
                        end
                    end else begin
                        hi_cnt_d = hi_inc;
                    end
                end
                ST_CONV: begin
                    if (rise_q) begin
                        pend_d   = 1'b1;
                        hi_cnt_d = CNT_W'(1);
                    end else if (pend_q) begin
                        hi_cnt_d = hi_inc;
                    end
                    if (div_done) begin
                        angle_d = clamp_angle(div_quo);
                        valid_d = 1'b1;
                        lost_d  = 1'b0;
                        pend_d  = 1'b0;
                        state_d = (pend_q || rise_q) ? ST_HIGH : ST_LOW;
                    end else if (!div_busy) begin
                        div_start = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hi_cnt_q <= '0;
            since_q  <= '0;
            pend_q   <= 1'b0;
            width_q  <= '0;
            angle_q  <= '0;
            valid_q  <= 1'b0;
            rerr_q   <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            since_q  <= since_d;
            pend_q   <= pend_d;
            width_q  <= width_d;
            angle_q  <= angle_d;
            valid_q  <= valid_d;
            rerr_q   <= rerr_d;
            lost_q   <= lost_d;
        end
    end

    pwm_angle_div #(
        .DIVISOR(CYC_PER_DEG)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (div_start),
        .dividend_i(div_dividend),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    assign angle_out   = angle_q;
    assign angle_valid = valid_q;
    assign width_out   = width_q;
    assign range_err   = rerr_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder: a scaled-timing instance for most scenarios plus one
// default-parameter instance decoding a single full-size pulse in the background.
module tb_servo_pwm_decoder;
    import servo_pwm_decoder_pkg::*;

    localparam int T_MIN = 100;
    localparam int T_MAX = 640;
    localparam int T_CPD = 3;
    localparam int T_TO  = 2000;
    localparam int DEF_W = SERVO_MIN_HIGH + 10 * SERVO_CYC_PER_DEG + 300;

    logic        clk = 1'b0;
    logic        rst_n, pwmIn, rstDefN, pwmDef;
    logic [7:0]  angleOut, angleDef;
    logic [31:0] widthOut, widthDef;
    logic        angleValid, validDef, rangeErr, rerrDef, signalLost, lostDef;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int validCnt = 0, rerrCnt = 0, validCntDef = 0, lastValidCyc = 0, fallCyc = 0;
    int expValid = 0, expRerr = 0, expAngle = 0, expWidth = 0;
    logic [7:0] gotAngles[$];

    servo_pwm_decoder #(
        .MIN_HIGH(T_MIN), .MAX_HIGH(T_MAX), .CYC_PER_DEG(T_CPD), .TIMEOUT_CYC(T_TO), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwmIn), .angle_out(angleOut), .angle_valid(angleValid),
        .width_out(widthOut), .range_err(rangeErr), .signal_lost(signalLost)
    );

    servo_pwm_decoder dutDef (
        .clk(clk), .rst_n(rstDefN), .pwm_in(pwmDef), .angle_out(angleDef), .angle_valid(validDef),
        .width_out(widthDef), .range_err(rerrDef), .signal_lost(lostDef)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Strobe monitor: outputs change on posedge, so each 1-cycle strobe is seen at exactly one negedge.
    always @(negedge clk) begin
        if (angleValid) begin
            validCnt++;
            lastValidCyc = cyc;
            gotAngles.push_back(angleOut);
        end
        if (rangeErr) rerrCnt++;
        if (validDef) validCntDef++;
    end

    function automatic int modelAngle(input int w);
        int q;
        q = (w - T_MIN) / T_CPD;
        return (q > 180) ? 180 : q;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int highCyc, input int lowCyc);
        pwmIn = 1'b1;
        repeat (highCyc) @(negedge clk);
        pwmIn = 1'b0;
        fallCyc = cyc + 1;
        repeat (lowCyc) @(negedge clk);
    endtask

    task automatic runPulse(input string tag, input int w, input int lowCyc);
        applyStimulus(w, lowCyc);
        if (w >= T_MIN && w <= T_MAX) begin
            expValid++;
            expAngle = modelAngle(w);
        end else begin
            expRerr++;
        end
        expWidth = (w > T_MAX) ? T_MAX + 1 : w;
        checkOutput({tag, ".width"}, widthOut, expWidth);
        checkOutput({tag, ".angle"}, {24'd0, angleOut}, expAngle);
        checkOutput({tag, ".valids"}, validCnt, expValid);
        checkOutput({tag, ".rangeErrs"}, rerrCnt, expRerr);
    endtask

    initial begin
        rst_n = 1'b0; rstDefN = 1'b0; pwmIn = 1'b0; pwmDef = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst.angle", {24'd0, angleOut}, 0);
        checkOutput("rst.valid", {31'd0, angleValid}, 0);
        checkOutput("rst.width", widthOut, 0);
        checkOutput("rst.rangeErr", {31'd0, rangeErr}, 0);
        checkOutput("rst.lost", {31'd0, signalLost}, 1);
        checkOutput("rstDef.lost", {31'd0, lostDef}, 1);
        rst_n = 1'b1; rstDefN = 1'b1;
        repeat (3) @(negedge clk);

        fork
            begin
                pwmDef = 1'b1;
                repeat (DEF_W) @(negedge clk);
                pwmDef = 1'b0;
            end
        join_none

        runPulse("mid90", 370, 40);
        checkOutput("mid90.latency", lastValidCyc - fallCyc, 12);
        checkOutput("mid90.lost", {31'd0, signalLost}, 0);

        runPulse("minEdge", T_MIN, 30);
        runPulse("maxEdge", T_MAX, 30);
        runPulse("min+1", T_MIN + 1, 30);
        runPulse("min+2", T_MIN + 2, 30);
        runPulse("min+3", T_MIN + 3, 30);
        runPulse("max-1", T_MAX - 1, 30);
        runPulse("min-1", T_MIN - 1, 30);
        runPulse("max+1", T_MAX + 1, 30);
        runPulse("spike5", 5, 30);
        runPulse("short", 80, 30);
        runPulse("long", 700, 30);

        for (int a = 1; a <= 179; a += 8) begin
            runPulse($sformatf("sweep%0d", a), a * T_CPD + T_MIN, 25);
            checkOutput($sformatf("round%0d", a), {24'd0, angleOut}, a);
        end

        for (int i = 0; i < 30; i++) begin
            int w, lowCyc;
            w = $urandom_range(T_MAX + 60, T_MIN - 60);
            lowCyc = $urandom_range(120, 20);
            runPulse($sformatf("rand%0d", i), w, lowCyc);
        end

        // Next rise arrives while the previous pulse is still converting.
        applyStimulus(370, 3);
        expValid++;
        runPulse("afterConv", 250, 40);
        checkOutput("inConv.angle", {24'd0, gotAngles[gotAngles.size() - 2]}, 90);

        runPulse("preLost", 250, 40);
        repeat (T_TO - 350) @(negedge clk);
        checkOutput("lostEarly", {31'd0, signalLost}, 0);
        repeat (100) @(negedge clk);
        checkOutput("lostSet", {31'd0, signalLost}, 1);
        checkOutput("lostHold.angle", {24'd0, angleOut}, expAngle);
        pwmIn = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("lostDuringHigh", {31'd0, signalLost}, 1);
        pwmIn = 1'b0;
        repeat (40) @(negedge clk);
        expValid++;
        expAngle = modelAngle(200);
        expWidth = 200;
        checkOutput("lostClear", {31'd0, signalLost}, 0);
        checkOutput("lostClear.angle", {24'd0, angleOut}, expAngle);
        checkOutput("lostClear.valids", validCnt, expValid);

        pwmIn = 1'b1;
        repeat (T_TO + 200) @(negedge clk);
        checkOutput("stuckHigh.lost", {31'd0, signalLost}, 1);
        checkOutput("stuckHigh.width", widthOut, expWidth);
        pwmIn = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("stuckHigh.widthAfter", widthOut, expWidth);
        checkOutput("stuckHigh.rangeErrs", rerrCnt, expRerr);
        checkOutput("stuckHigh.valids", validCnt, expValid);
        runPulse("recover", 400, 40);
        checkOutput("recover.lost", {31'd0, signalLost}, 0);

        pwmIn = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midRst.width", widthOut, 0);
        checkOutput("midRst.lost", {31'd0, signalLost}, 1);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        pwmIn = 1'b0;
        repeat (40) @(negedge clk);
        expWidth = 0;
        expAngle = 0;
        checkOutput("rstIgnored.width", widthOut, 0);
        checkOutput("rstIgnored.valids", validCnt, expValid);
        checkOutput("rstIgnored.rangeErrs", rerrCnt, expRerr);
        runPulse("postRst", 250, 40);

        for (int k = 0; k < 40000 && validCntDef == 0; k++) @(negedge clk);
        checkOutput("def.valids", validCntDef, 1);
        checkOutput("def.angle", {24'd0, angleDef}, 10);
        checkOutput("def.width", widthDef, DEF_W);
        checkOutput("def.lost", {31'd0, lostDef}, 0);
        checkOutput("def.rangeErr", {31'd0, rerrDef}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
